fir_sym_fold: RTL and testbench

Parametrised, time-multiplexed symmetric FIR filter. It is the generalised successor of the fixed 20-tap IQ-demod channel filter.
- Even tap count, data/coefficient/output widths and multiplier count are parameters.
- Coefficients are runtime-programmable.
- Adds a valid/ready input handshake, runtime round/saturate modes, a saturation flag and a synchronous flush.
- Instantiated once per I and Q rail in iq_demod.

---
 rtl/fir_sym_fold.sv | 149 ++++++++++++++
 tb/tb_fir_sym_fold.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_sym_fold.sv
// Time-multiplexed symmetric FIR: folds x[j]+x[NTAPS-1-j] and runs NMULT MACs per cycle, CYC+1 cycles per sample.
// in_ready is high only in IDLE; samples offered while busy are not taken and must be held upstream.
module fir_sym_fold #(
    parameter int DATA_W    = 5,
    parameter int COEF_W    = 9,
    parameter int NTAPS     = 20,
    parameter int NMULT     = 2,
    parameter int OUT_W     = 5,
    parameter int OUT_SHIFT = 9,
    localparam int NPAIR    = NTAPS / 2,
    localparam int AW       = (NPAIR > 1) ? $clog2(NPAIR) : 1
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] data_in,
    input  logic                     clear,
    input  logic                     round_en,
    input  logic                     sat_en,
    input  logic                     coef_we,
    input  logic [AW-1:0]            coef_addr,
    input  logic signed [COEF_W-1:0] coef_wdata,
    output logic signed [OUT_W-1:0]  data_out,
    output logic                     out_valid,
    output logic                     out_sat
);

    localparam int CYC   = (NPAIR + NMULT - 1) / NMULT;
    localparam int KW    = (CYC > 1) ? $clog2(CYC) : 1;
    localparam int XIW   = $clog2(NTAPS);
    localparam int SUM_W = DATA_W + 1;
    localparam int PW    = DATA_W + COEF_W + 1;
    localparam int ACC_W = PW + $clog2(NPAIR);
    localparam int XW    = (ACC_W + 1 > OUT_W + 1) ? ACC_W + 1 : OUT_W + 1;

    localparam logic signed [XW-1:0] RND  = {{(XW-1){1'b0}}, 1'b1} << (OUT_SHIFT - 1);
    localparam logic signed [XW-1:0] MAXV = {{(XW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [XW-1:0] MINV = {{(XW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    if (NTAPS < 2 || NTAPS % 2 != 0) begin : g_bad_ntaps
        $error("fir_sym_fold: NTAPS must be even and >= 2");
    end

    typedef enum logic {IDLE, MAC} state_t;

    state_t                    state;
    logic [KW-1:0]             k;
    logic signed [DATA_W-1:0]  x [NTAPS];
    logic signed [COEF_W-1:0]  c [NPAIR];
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   mac_sum;
    logic signed [ACC_W-1:0]   acc_next;
    logic signed [SUM_W-1:0]   pair;
    logic signed [PW-1:0]      prod;
    logic [XIW-1:0]            xa;
    logic [XIW-1:0]            xb;
    logic [AW-1:0]             ca;
    int                        j;
    logic signed [XW-1:0]      v;
    logic signed [XW-1:0]      s;
    logic                      sat_hi;
    logic                      sat_lo;
    logic signed [OUT_W-1:0]   data_nxt;

    assign in_ready = (state == IDLE);

    // Pairs with j >= NPAIR (last, partially filled slot) contribute nothing.
    always_comb begin
        mac_sum = '0;
        pair    = '0;
        prod    = '0;
        xa      = '0;
        xb      = '0;
        ca      = '0;
        j       = 0;
        for (int m = 0; m < NMULT; m++) begin
            j = int'(k) * NMULT + m;
            if (j < NPAIR) begin
                xa      = XIW'(j);
                xb      = XIW'(NTAPS - 1 - j);
                ca      = AW'(j);
                pair    = SUM_W'(x[xa]) + SUM_W'(x[xb]);
                prod    = PW'(pair) * PW'(c[ca]);
                mac_sum = mac_sum + ACC_W'(prod);
            end
        end
    end

    assign acc_next = acc + mac_sum;

    always_comb begin
        v        = XW'(acc_next) + (round_en ? RND : '0);
        s        = v >>> OUT_SHIFT;
        sat_hi   = (s > MAXV);
        sat_lo   = (s < MINV);
        data_nxt = s[OUT_W-1:0];
        if (sat_en && sat_hi) data_nxt = MAXV[OUT_W-1:0];
        if (sat_en && sat_lo) data_nxt = MINV[OUT_W-1:0];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            k         <= '0;
            acc       <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
            out_sat   <= 1'b0;
            for (int i = 0; i < NTAPS; i++) x[i] <= '0;
            for (int i = 0; i < NPAIR; i++) c[i] <= '0;
        end else begin
            out_valid <= 1'b0;
            if (coef_we && int'(coef_addr) < NPAIR) c[coef_addr] <= coef_wdata;
            // Flush wins over acceptance and over the final MAC cycle, so an aborted sample never emits.
            if (clear) begin
                state <= IDLE;
                k     <= '0;
                acc   <= '0;
                for (int i = 0; i < NTAPS; i++) x[i] <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (in_valid) begin
                            x[0] <= data_in;
                            for (int i = 1; i < NTAPS; i++) x[i] <= x[i-1];
                            acc   <= '0;
                            k     <= '0;
                            state <= MAC;
                        end
                    end
                    MAC: begin
                        acc <= acc_next;
                        if (k == KW'(CYC - 1)) begin
                            state     <= IDLE;
                            data_out  <= data_nxt;
                            out_sat   <= sat_hi | sat_lo;
                            out_valid <= 1'b1;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fir_sym_fold.sv
// Directed bench for fir_sym_fold at default parameters plus a small-parameter instance against a reference model.
module tb_fir_sym_fold;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn, in_valid, clear, round_en, sat_en, coef_we;
    logic       in_ready, out_valid, out_sat;
    logic [4:0] data_in, data_out;
    logic [3:0] coef_addr;
    logic [8:0] coef_wdata;

    logic       in_valid2, clear2, round_en2, sat_en2, coef_we2;
    logic       in_ready2, out_valid2, out_sat2;
    logic [5:0] data_in2;
    logic [7:0] data_out2;
    logic [1:0] coef_addr2;
    logic [6:0] coef_wdata2;

    int checks = 0;
    int passed = 0;

    fir_sym_fold dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .clear(clear), .round_en(round_en), .sat_en(sat_en),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .data_out(data_out), .out_valid(out_valid), .out_sat(out_sat)
    );

    fir_sym_fold #(.DATA_W(6), .COEF_W(7), .NTAPS(8), .NMULT(3), .OUT_W(8), .OUT_SHIFT(5)) dut2 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid2), .in_ready(in_ready2),
        .data_in(data_in2), .clear(clear2), .round_en(round_en2), .sat_en(sat_en2),
        .coef_we(coef_we2), .coef_addr(coef_addr2), .coef_wdata(coef_wdata2),
        .data_out(data_out2), .out_valid(out_valid2), .out_sat(out_sat2)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int val);
        coef_we    = 1'b1;
        coef_addr  = 4'(a);
        coef_wdata = 9'(val);
        tick();
        coef_we    = 1'b0;
    endtask

    task automatic do_clear;
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic send(input int d, output int dout, output int sat);
        int n;
        int lat;
        n        = 0;
        in_valid = 1'b1;
        data_in  = 5'(d);
        while (!in_ready && n < 20) begin tick(); n++; end
        tick();
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 20) begin tick(); lat++; end
        chk("latency", lat, 6);
        dout = int'($signed(data_out));
        sat  = int'(out_sat);
    endtask

    task automatic run_impulse(input logic rnd, output int o1, output int o20, output int others);
        int o;
        int s;
        round_en = rnd;
        sat_en   = 1'b1;
        others   = 0;
        send(15, o1, s);
        for (int i = 1; i < 19; i++) begin
            send(0, o, s);
            if (o != 0) others++;
        end
        send(0, o20, s);
    endtask

    initial begin
        int o1, o20, oth, d, s, nv, acc_cnt;
        int xm [8];
        int cm [4];
        longint acc, v, sh;
        logic [7:0] lo8;
        int ed, es, lat, n, dv, a, cv;
        logic rnd, sat;

        resetn = 1'b0; in_valid = 1'b0; clear = 1'b0; round_en = 1'b0; sat_en = 1'b1;
        coef_we = 1'b0; coef_addr = '0; coef_wdata = '0; data_in = '0;
        in_valid2 = 1'b0; clear2 = 1'b0; round_en2 = 1'b0; sat_en2 = 1'b0;
        coef_we2 = 1'b0; coef_addr2 = '0; coef_wdata2 = '0; data_in2 = '0;
        #12;
        chk("rst_data_out", int'(data_out), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_sat", int'(out_sat), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        resetn = 1'b1;
        tick();

        // Impulse response, truncate then round
        wr(0, 128);
        run_impulse(1'b0, o1, o20, oth);
        chk("imp_trunc_o1", o1, 3);
        chk("imp_trunc_o20", o20, 3);
        chk("imp_trunc_others", oth, 0);
        run_impulse(1'b1, o1, o20, oth);
        chk("imp_round_o1", o1, 4);
        chk("imp_round_o20", o20, 4);
        chk("imp_round_others", oth, 0);

        // Negative coefficient: floor vs round-half-up
        do_clear();
        wr(0, -256);
        round_en = 1'b0;
        send(15, d, s);
        chk("neg_trunc", d, -8);
        chk("neg_trunc_sat", s, 0);
        round_en = 1'b1;
        send(15, d, s);
        chk("neg_round", d, -7);
        chk("neg_round_sat", s, 0);

        // Saturation and wrap
        do_clear();
        for (int j = 0; j < 10; j++) wr(j, 255);
        round_en = 1'b0;
        sat_en   = 1'b1;
        send(15, d, s);
        chk("sat_first", d, 7);
        chk("sat_first_flag", s, 0);
        for (int i = 1; i < 20; i++) send(15, d, s);
        chk("sat_clamp", d, 15);
        chk("sat_clamp_flag", s, 1);
        sat_en = 1'b0;
        send(15, d, s);
        chk("sat_wrap", d, -11);
        chk("sat_wrap_flag", s, 1);

        // Handshake with in_valid held high
        do_clear();
        in_valid = 1'b1;
        data_in  = '0;
        acc_cnt  = 0;
        for (int c = 0; c < 30; c++) begin
            chk($sformatf("hs_in_ready_c%0d", c), int'(in_ready), (c % 6 == 0) ? 1 : 0);
            chk($sformatf("hs_out_valid_c%0d", c), int'(out_valid), (c % 6 == 0 && c > 0) ? 1 : 0);
            if (in_ready) acc_cnt++;
            tick();
        end
        in_valid = 1'b0;
        chk("hs_out_valid_c30", int'(out_valid), 1);
        chk("hs_accepts", acc_cnt, 5);
        for (int i = 0; i < 6; i++) tick();

        // Abort via clear at MAC k=2
        sat_en   = 1'b1;
        round_en = 1'b0;
        for (int j = 1; j < 10; j++) wr(j, 0);
        wr(0, 128);
        do_clear();
        in_valid = 1'b1;
        data_in  = 5'd15;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("abort_in_ready", int'(in_ready), 1);
        nv = 0;
        for (int i = 0; i < 10; i++) begin if (out_valid) nv++; tick(); end
        chk("abort_no_valid", nv, 0);
        run_impulse(1'b0, o1, o20, oth);
        chk("abort_imp_o1", o1, 3);
        chk("abort_imp_o20", o20, 3);
        chk("abort_imp_others", oth, 0);

        // Abort via reset at MAC k=2
        in_valid = 1'b1;
        data_in  = 5'd15;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2 resetn = 1'b0;
        #2;
        chk("rstmid_in_ready", int'(in_ready), 1);
        chk("rstmid_out_valid", int'(out_valid), 0);
        chk("rstmid_data_out", int'(data_out), 0);
        resetn = 1'b1;
        tick();
        nv = 0;
        for (int i = 0; i < 10; i++) begin if (out_valid) nv++; tick(); end
        chk("rstmid_no_valid", nv, 0);
        run_impulse(1'b0, o1, o20, oth);
        chk("rstmid_imp_o1", o1, 0);
        chk("rstmid_imp_o20", o20, 0);
        chk("rstmid_imp_others", oth, 0);

        // Small-parameter instance against a reference model
        for (int i = 0; i < 8; i++) xm[i] = 0;
        for (int j = 0; j < 4; j++) begin
            cv = int'($urandom_range(0, 127)) - 64;
            cm[j] = cv;
            coef_we2 = 1'b1; coef_addr2 = 2'(j); coef_wdata2 = 7'(cv);
            tick();
        end
        coef_we2 = 1'b0;
        for (int it = 0; it < 200; it++) begin
            a  = int'($urandom_range(0, 3));
            cv = int'($urandom_range(0, 127)) - 64;
            cm[a] = cv;
            coef_we2 = 1'b1; coef_addr2 = 2'(a); coef_wdata2 = 7'(cv);
            tick();
            coef_we2 = 1'b0;
            dv  = int'($urandom_range(0, 63)) - 32;
            rnd = 1'($urandom_range(0, 1));
            sat = 1'($urandom_range(0, 1));
            round_en2 = rnd;
            sat_en2   = sat;
            in_valid2 = 1'b1;
            data_in2  = 6'(dv);
            n = 0;
            while (!in_ready2 && n < 20) begin tick(); n++; end
            tick();
            in_valid2 = 1'b0;
            lat = 1;
            while (!out_valid2 && lat < 20) begin tick(); lat++; end

            for (int i = 7; i > 0; i--) xm[i] = xm[i-1];
            xm[0] = dv;
            acc = 0;
            for (int j = 0; j < 4; j++) acc += longint'(cm[j]) * longint'(xm[j] + xm[7-j]);
            v  = acc + (rnd ? 64'sd16 : 64'sd0);
            sh = v >>> 5;
            lo8 = sh[7:0];
            es = 0;
            ed = int'(sh);
            if (sh > 127 || sh < -128) begin
                es = 1;
                if (sat) ed = (sh > 127) ? 127 : -128;
                else     ed = int'($signed(lo8));
            end
            chk($sformatf("sweep%0d_latency", it), lat, 3);
            chk($sformatf("sweep%0d_data", it), int'($signed(data_out2)), ed);
            chk($sformatf("sweep%0d_sat", it), int'(out_sat2), es);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
